uart_tx_ext: RTL
================

# uart_tx_ext

Parametrised next-generation UART transmitter. It serialises one word per frame, LSB first, with configurable data width, oversampling ratio, stop-bit count and runtime parity mode. A valid/ready handshake replaces the single-cycle start strobe. It sits between the TX FIFO read port and the pad, paced by the shared `s_tick` baud-tick generator (`timer_input`).

## Interface
- `DBIT`, 8, data bits per frame; legal range 5..9.
- `OS_TICK`, 16, `s_tick` pulses per bit period; legal range 8..32.
- `STOP_BITS`, 1, stop-bit count; legal values 1 or 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_tick`  in  1  one-cycle oversampling tick enable.
- `tx_din`  in  DBIT  word to transmit; sampled on accept.
- `tx_valid`  in  1  a word is offered on `tx_din`.
- `tx_ready`  out  1  transmitter can accept a word this cycle.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none; sampled on accept.
- `tx_busy`  out  1  a frame is in progress.
- `tx_done_tick`  out  1  one-cycle pulse at the end of a frame.
- `tx`  out  1  serial line, registered, idle high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Tick counter: width $clog2(OS_TICK*2). Bit counter: width $clog2(DBIT+1).
- IDLE: `tx`=1, `tx_ready`=1, `tx_busy`=0.
  - Accept occurs when `tx_valid` && `tx_ready` at a clock edge.
  - On accept: latch `tx_din` and `parity_mode`, clear the tick counter, go to START.
- START: `tx`=0. After OS_TICK ticks, go to DATA with bit counter 0.
- DATA: `tx` = shift[0]. Every OS_TICK ticks, shift right and increment the bit counter.
  - After bit DBIT-1, go to PARITY if the latched mode is even or odd, else go to STOP.
- PARITY: `tx` is the parity bit for OS_TICK ticks, then go to STOP.
  - Even parity: `tx` = ^data.
  - Odd parity: `tx` = ~^data.
- STOP: `tx`=1 for STOP_BITS*OS_TICK ticks. Then pulse `tx_done_tick` and return to IDLE.
- Ticks only count in cycles where `s_tick`=1. A bit boundary is the tick on which the counter equals its terminal value; the counter then clears.
- `tx_din` and `parity_mode` changes mid-frame are ignored.
- `tx_valid` held high during a frame is not accepted until `tx_ready` returns high.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done_tick`=0, state IDLE, counters 0.
- Reset mid-frame aborts the frame. `tx` is 1 from the edge after reset is sampled; no `tx_done_tick` is issued.
- Accept edge: on that same edge `tx` goes 0, `tx_ready` goes 0 and `tx_busy` goes 1.
- Frame length is (1 + DBIT + P + STOP_BITS) * OS_TICK ticks, where P is 1 if parity is enabled, else 0.
  - The start bit may be up to one tick short, because `s_tick` phase is free-running.
- `tx_done_tick` is high for exactly the one cycle after the final stop tick. In that same cycle `tx_ready`=1 and `tx_busy`=0.
- Back-to-back frames: if `tx_valid` is high during the `tx_done_tick` cycle, the next word is accepted on that edge. There are zero idle cycles between the stop bit and the next start bit.
- `s_tick` coincident with accept is not counted toward the start bit.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: the PARITY state and parity generation are compiled in, and `parity_mode` behaves as above.
  - Undefined: the PARITY state is removed and `parity_mode` is accepted but ignored. Frames are always start + DBIT + stop, and the port list is unchanged.

## Test plan
- Default parameters, `s_tick` every 16 clocks, send 8'hAB with mode 00 -> `tx` sequence 0,1,1,0,1,0,1,0,1,1, each bit 256 clocks. `tx_done_tick` fires once, 2560 ±16 clocks after accept.
- Macro defined, 8'hAB with mode 01 -> parity bit 1; with mode 10 -> parity bit 0. Frames are 11 bits.
- Macro undefined, 8'hAB with mode 01 -> 10-bit frame identical to the mode-00 case.
- Two words 8'h55 and 8'h0F with `tx_valid` held high, STOP_BITS=2 -> the second start bit begins the cycle after `tx_done_tick`. The stop interval is 512 clocks and `tx_ready` is low for the whole of both frames.
- `reset` asserted during the DATA of 8'hAB -> next edge `tx`=1, `tx_ready`=1, no done pulse. A fresh word is then sent correctly.
- DBIT=5, OS_TICK=8, send 5'h13 -> 7-bit frame 0,1,1,0,0,1,1, each bit 8 ticks.

Source files
------------

// File: rtl/uart_tx_ext.sv
// UART transmitter: one valid/ready word per frame, sent LSB first with optional parity, paced by s_tick.
// Latency: tx drops to the start level on the accept edge; the frame lasts (1+DBIT+P+STOP_BITS)*OS_TICK ticks.
// Backpressure: tx_ready is high only while idle, including the tx_done_tick cycle, so back-to-back words leave no gap.
//
// Ports: clk, reset (synchronous, active-high), s_tick (oversampling tick enable),
//        tx_din/tx_valid/tx_ready (word handshake), parity_mode (00 none, 01 even, 10 odd, 11 none),
//        tx_busy, tx_done_tick (one cycle after the last stop tick), tx (registered serial line, idle high).
// Build option: define UART_TX_PARITY_EN to compile in the parity bit. Without it, parity_mode is ignored.
module uart_tx_ext #(
    parameter int DBIT      = 8,   // data bits per frame, 5..9
    parameter int OS_TICK   = 16,  // s_tick pulses per bit, 8..32
    parameter int STOP_BITS = 1    // 1 or 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic [DBIT-1:0] tx_din,
    input  logic            tx_valid,
    output logic            tx_ready,
    input  logic [1:0]      parity_mode,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    localparam int TW = $clog2(OS_TICK * 2);
    localparam int BW = $clog2(DBIT + 1);

    // Terminal tick counts: a bit ends on the tick where the counter equals these.
    localparam logic [TW-1:0] BIT_LAST_TICK  = TW'(OS_TICK - 1);
    localparam logic [TW-1:0] STOP_LAST_TICK = TW'(STOP_BITS * OS_TICK - 1);
    localparam logic [BW-1:0] LAST_BIT       = BW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

`ifdef UART_TX_PARITY_EN
    // Parity is computed at accept time because the shift register is consumed as the frame goes out.
    logic par_en_q, par_en_d;
    logic par_bit_q, par_bit_d;
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif

        case (state_q)
            IDLE: begin
                // An s_tick coinciding with accept is deliberately not counted.
                if (tx_valid) begin
                    shift_d = tx_din;
                    tick_d  = '0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    par_bit_d = (parity_mode == 2'b10) ? ~(^tx_din) : (^tx_din);
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == BIT_LAST_TICK) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == BIT_LAST_TICK) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state_d = par_en_q ? PARITY : STOP;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (tick_q == BIT_LAST_TICK) begin
                        tick_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (tick_q == STOP_LAST_TICK) begin
                        tick_d  = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase

        // Outputs are decoded from the next state so they are registered yet change on the same edge as the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_bit_d;
`endif
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

    assign tx           = tx_q;
    assign tx_ready     = ready_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;

endmodule
